// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : N-channel cache-to-memory arbiter, one transaction at a time.
//           Round-robin by default; ARB_FIXED_PRIO_EN selects lowest-index-wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            creq,
  input  logic [NUM_CH-1:0]            cwrite,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] caddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] cwdata,
  output logic [DATA_WIDTH-1:0]        crdata,
  output logic [NUM_CH-1:0]            cack_n,
  output logic [NUM_CH-1:0]            cbusy,
  output logic [ADDR_WIDTH-1:0]        maddr,
  output logic                         mreq,
  output logic                         mwrite,
  output logic [DATA_WIDTH-1:0]        mwdata,
  input  logic [DATA_WIDTH-1:0]        mrdata,
  input  logic                         ack_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PTR_WIDTH-1:0]   r_grant;
  logic [DATA_WIDTH-1:0]  r_crdata;
  logic [NUM_CH-1:0]      r_cack_n;
  logic [NUM_CH-1:0]      r_cbusy;
  logic [ADDR_WIDTH-1:0]  r_maddr;
  logic                   r_mreq;
  logic                   r_mwrite;
  logic [DATA_WIDTH-1:0]  r_mwdata;
`ifndef ARB_FIXED_PRIO_EN
  logic [PTR_WIDTH-1:0]   r_rr_ptr;
`endif

  int                     w_sel;
  logic                   w_any;
  logic [PTR_WIDTH-1:0]   w_winner;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic                   w_write;

  always_comb begin
    w_sel   = 0;
    w_any   = |creq;
    w_addr  = '0;
    w_wdata = '0;
    w_write = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (creq[i]) w_sel = i;
    end
`else
    // Descending k so the smallest rotation distance from r_rr_ptr wins last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (creq[i] && (i == (int'(r_rr_ptr) + k) % NUM_CH)) w_sel = i;
      end
    end
`endif
    w_winner = PTR_WIDTH'(w_sel);
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == w_sel) begin
        w_addr  = caddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = cwdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_write = cwrite[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_crdata <= '0;
      r_cack_n <= '1;
      r_cbusy  <= '0;
      r_maddr  <= '0;
      r_mreq   <= 1'b0;
      r_mwrite <= 1'b0;
      r_mwdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cack_n <= '1;
          if (w_any) begin
            r_grant  <= w_winner;
            r_maddr  <= w_addr;
            r_mwrite <= w_write;
            r_mwdata <= w_wdata;
            r_mreq   <= 1'b1;
            r_cbusy  <= ~(NUM_CH'(1) << w_winner);
            r_state  <= S_ISSUE;
          end else begin
            r_mreq  <= 1'b0;
            r_cbusy <= '0;
          end
        end
        S_ISSUE: begin
          if (!ack_n) begin
            r_crdata <= mrdata;
            r_mreq   <= 1'b0;
            r_cack_n <= ~(NUM_CH'(1) << r_grant);
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_cack_n <= '1;
          r_cbusy  <= '0;
`ifndef ARB_FIXED_PRIO_EN
          if (int'(r_grant) == NUM_CH - 1) r_rr_ptr <= '0;
          else                             r_rr_ptr <= r_grant + 1'b1;
`endif
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign crdata = r_crdata;
  assign cack_n = r_cack_n;
  assign cbusy  = r_cbusy;
  assign maddr  = r_maddr;
  assign mreq   = r_mreq;
  assign mwrite = r_mwrite;
  assign mwdata = r_mwdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter (2- and 4-channel).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      creq2 = '0, cwrite2 = '0, cack2, cbusy2;
  logic [2*AW-1:0] caddr2 = '0;
  logic [2*DW-1:0] cwdata2 = '0;
  logic [DW-1:0]   crdata2, mwdata2, mrdata2 = '0;
  logic [AW-1:0]   maddr2;
  logic            mreq2, mwrite2, ack2_n = 1'b1;

  logic [3:0]      creq4 = '0, cwrite4 = '0, cack4, cbusy4;
  logic [4*AW-1:0] caddr4 = '0;
  logic [4*DW-1:0] cwdata4 = '0;
  logic [DW-1:0]   crdata4, mwdata4, mrdata4 = '0;
  logic [AW-1:0]   maddr4;
  logic            mreq4, mwrite4, ack4_n = 1'b1;

  mem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(3)) u_dut2 (
    .clk(clk), .rst(rst), .creq(creq2), .cwrite(cwrite2), .caddr(caddr2), .cwdata(cwdata2),
    .crdata(crdata2), .cack_n(cack2), .cbusy(cbusy2), .maddr(maddr2), .mreq(mreq2),
    .mwrite(mwrite2), .mwdata(mwdata2), .mrdata(mrdata2), .ack_n(ack2_n));

  mem_arbiter #(.NUM_CH(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(3)) u_dut4 (
    .clk(clk), .rst(rst), .creq(creq4), .cwrite(cwrite4), .caddr(caddr4), .cwdata(cwdata4),
    .crdata(crdata4), .cack_n(cack4), .cbusy(cbusy4), .maddr(maddr4), .mreq(mreq4),
    .mwrite(mwrite4), .mwdata(mwdata4), .mrdata(mrdata4), .ack_n(ack4_n));

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_crdata = '0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_tests++; if (mreq2 !== 1'b0) begin n_fail++; $display("FAIL reset_mreq got %b exp 0", mreq2); end
    n_tests++; if (mwrite2 !== 1'b0 || maddr2 !== '0 || mwdata2 !== '0) begin
      n_fail++; $display("FAIL reset_mport got w=%b a=%h d=%h exp zeros", mwrite2, maddr2, mwdata2); end
    n_tests++; if (cack2 !== 2'b11 || cbusy2 !== 2'b00) begin
      n_fail++; $display("FAIL reset_cack_cbusy got %b/%b exp 11/00", cack2, cbusy2); end
    n_tests++; if (crdata2 !== '0) begin n_fail++; $display("FAIL reset_crdata got %h exp 0", crdata2); end
  endtask

  task automatic test_single_read;
    caddr2[0 +: AW] = 32'h0000_1000;
    cwrite2 = 2'b00;
    creq2   = 2'b01;
    step();
    n_tests++; if (mreq2 !== 1'b1 || maddr2 !== 32'h1000 || mwrite2 !== 1'b0) begin
      n_fail++; $display("FAIL read_issue got req=%b a=%h w=%b exp 1/1000/0", mreq2, maddr2, mwrite2); end
    n_tests++; if (cbusy2 !== 2'b10 || cack2 !== 2'b11) begin
      n_fail++; $display("FAIL read_issue_busy got busy=%b ack=%b exp 10/11", cbusy2, cack2); end
    step();
    n_tests++; if (mreq2 !== 1'b1 || cack2 !== 2'b11) begin
      n_fail++; $display("FAIL read_wait got req=%b ack=%b exp 1/11", mreq2, cack2); end
    ack2_n = 1'b0; mrdata2 = {32{8'hA5}}; exp_crdata = {32{8'hA5}};
    step();
    ack2_n = 1'b1; creq2 = 2'b00;
    n_tests++; if (cack2 !== 2'b10 || crdata2 !== exp_crdata) begin
      n_fail++; $display("FAIL read_resp got ack=%b rd=%h exp 10/%h", cack2, crdata2, exp_crdata); end
    n_tests++; if (cbusy2 !== 2'b10 || mreq2 !== 1'b0) begin
      n_fail++; $display("FAIL read_resp_busy got busy=%b req=%b exp 10/0", cbusy2, mreq2); end
    step();
    n_tests++; if (cack2 !== 2'b11 || cbusy2 !== 2'b00 || crdata2 !== exp_crdata) begin
      n_fail++; $display("FAIL read_idle got ack=%b busy=%b rd=%h", cack2, cbusy2, crdata2); end
  endtask

  task automatic test_write;
    caddr2[AW +: AW]  = 32'h0000_2000;
    cwdata2[DW +: DW] = {8{32'hDEADBEEF}};
    cwrite2 = 2'b10;
    creq2   = 2'b10;
    step();
    n_tests++; if (mreq2 !== 1'b1 || mwrite2 !== 1'b1 || maddr2 !== 32'h2000) begin
      n_fail++; $display("FAIL write_issue got req=%b w=%b a=%h exp 1/1/2000", mreq2, mwrite2, maddr2); end
    n_tests++; if (mwdata2 !== {8{32'hDEADBEEF}} || cbusy2 !== 2'b01) begin
      n_fail++; $display("FAIL write_data got d=%h busy=%b", mwdata2, cbusy2); end
    ack2_n = 1'b0; mrdata2 = {16{16'h1234}}; exp_crdata = {16{16'h1234}};
    step();
    ack2_n = 1'b1; creq2 = 2'b00; cwrite2 = 2'b00;
    n_tests++; if (cack2 !== 2'b01 || crdata2 !== exp_crdata) begin
      n_fail++; $display("FAIL write_resp got ack=%b rd=%h exp 01/%h", cack2, crdata2, exp_crdata); end
    step();
    n_tests++; if (cack2 !== 2'b11 || mreq2 !== 1'b0) begin
      n_fail++; $display("FAIL write_pulse_len got ack=%b req=%b exp 11/0", cack2, mreq2); end
  endtask

  task automatic test_contention;
    int exp_g [4];
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    caddr2[0 +: AW]  = 32'h0000_0100;
    caddr2[AW +: AW] = 32'h0000_0200;
    creq2 = 2'b11;
    for (int n = 0; n < 4; n++) begin
      step();
      n_tests++; if (maddr2 !== (exp_g[n] == 0 ? 32'h100 : 32'h200) || mreq2 !== 1'b1) begin
        n_fail++; $display("FAIL contention_grant%0d got a=%h req=%b exp ch%0d", n, maddr2, mreq2, exp_g[n]); end
      ack2_n = 1'b0; mrdata2 = DW'(n + 1); exp_crdata = DW'(n + 1);
      step();
      ack2_n = 1'b1;
      if (n == 3) creq2 = 2'b00;
      n_tests++; if (cack2 !== (exp_g[n] == 0 ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_ack%0d got %b exp ch%0d low", n, cack2, exp_g[n]); end
      step();
    end
  endtask

  task automatic test_reset_mid;
    creq2 = 2'b01;
    step();
    ack2_n = 1'b0; mrdata2 = {8{32'h0BAD_F00D}};
    step();
    ack2_n = 1'b1;
    step();
    step();
    rst = 1'b1; ack2_n = 1'b0; mrdata2 = {8{32'hCAFE_0001}};
    n_tests++; if (mreq2 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got req=%b exp 1", mreq2); end
    step();
    rst = 1'b0; ack2_n = 1'b1; creq2 = 2'b11;
    n_tests++; if (mreq2 !== 1'b0 || cack2 !== 2'b11 || crdata2 !== '0 || cbusy2 !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_vals got req=%b ack=%b busy=%b rd=%h", mreq2, cack2, cbusy2, crdata2); end
    step();
    n_tests++; if (maddr2 !== 32'h100 || cbusy2 !== 2'b10 || cack2 !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_regrant got a=%h busy=%b ack=%b exp 100/10/11", maddr2, cbusy2, cack2); end
    ack2_n = 1'b0; mrdata2 = {8{32'h5555_AAAA}}; exp_crdata = {8{32'h5555_AAAA}};
    step();
    ack2_n = 1'b1; creq2 = 2'b00;
    n_tests++; if (cack2 !== 2'b10 || crdata2 !== exp_crdata) begin
      n_fail++; $display("FAIL rstmid_resp got ack=%b rd=%h", cack2, crdata2); end
    step();
  endtask

  task automatic test_spurious_dropped;
    ack2_n = 1'b0; mrdata2 = {32{8'h77}};
    step();
    step();
    n_tests++; if (mreq2 !== 1'b0 || cack2 !== 2'b11 || cbusy2 !== 2'b00 || crdata2 !== exp_crdata) begin
      n_fail++; $display("FAIL spurious_idle got req=%b ack=%b busy=%b rd=%h", mreq2, cack2, cbusy2, crdata2); end
    ack2_n = 1'b1; creq2 = 2'b01;
    step();
    creq2 = 2'b00;
    n_tests++; if (mreq2 !== 1'b1 || maddr2 !== 32'h100) begin
      n_fail++; $display("FAIL drop_issue got req=%b a=%h exp 1/100", mreq2, maddr2); end
    step();
    n_tests++; if (mreq2 !== 1'b1 || cack2 !== 2'b11) begin
      n_fail++; $display("FAIL drop_hold got req=%b ack=%b exp 1/11", mreq2, cack2); end
    ack2_n = 1'b0; mrdata2 = {32{8'h3C}}; exp_crdata = {32{8'h3C}};
    step();
    ack2_n = 1'b1;
    n_tests++; if (cack2 !== 2'b10 || crdata2 !== exp_crdata) begin
      n_fail++; $display("FAIL drop_resp got ack=%b rd=%h", cack2, crdata2); end
    step();
    step();
    n_tests++; if (cack2 !== 2'b11 || mreq2 !== 1'b0) begin
      n_fail++; $display("FAIL drop_once got ack=%b req=%b exp 11/0", cack2, mreq2); end
  endtask

  task automatic test_wrap4;
    for (int i = 0; i < 4; i++) caddr4[i*AW +: AW] = 32'h4000 + 32'(i);
    creq4 = 4'b0100;
    step();
    n_tests++; if (maddr4 !== 32'h4002 || cbusy4 !== 4'b1011) begin
      n_fail++; $display("FAIL wrap_ch2 got a=%h busy=%b exp 4002/1011", maddr4, cbusy4); end
    ack4_n = 1'b0;
    step();
    ack4_n = 1'b1; creq4 = 4'b0000;
    n_tests++; if (cack4 !== 4'b1011) begin n_fail++; $display("FAIL wrap_ack2 got %b exp 1011", cack4); end
    step();
    creq4 = 4'b0011;
    step();
    n_tests++; if (maddr4 !== 32'h4000 || cbusy4 !== 4'b1110) begin
      n_fail++; $display("FAIL wrap_ch0 got a=%h busy=%b exp 4000/1110", maddr4, cbusy4); end
    ack4_n = 1'b0;
    step();
    ack4_n = 1'b1; creq4 = 4'b0010;
    n_tests++; if (cack4 !== 4'b1110) begin n_fail++; $display("FAIL wrap_ack0 got %b exp 1110", cack4); end
    step();
    step();
    n_tests++; if (maddr4 !== 32'h4001 || mreq4 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ch1 got a=%h req=%b exp 4001/1", maddr4, mreq4); end
    ack4_n = 1'b0;
    step();
    ack4_n = 1'b1; creq4 = 4'b0000;
    n_tests++; if (cack4 !== 4'b1101) begin n_fail++; $display("FAIL wrap_ack1 got %b exp 1101", cack4); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_reset_mid();
    test_spurious_dropped();
    test_wrap4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
